// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use / RAW bubbles, branch flushes and a
// structural stall while a MEM-stage access occupies the shared instruction RAM.
module pipe_hazard_ctrl #(
  parameter int unsigned REG_AW   = 4,
  parameter int unsigned N_RD     = 2,
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned FWD_EN   = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_RD*REG_AW-1:0] id_rreg,
  input  logic [N_RD-1:0]        id_use,
  input  logic [REG_AW-1:0]      ex_wreg,
  input  logic                   ex_wen,
  input  logic                   ex_memread,
  input  logic                   ex_branch_taken,
  input  logic [REG_AW-1:0]      mem_wreg,
  input  logic                   mem_wen,
  input  logic                   mem_conflict,
  output logic                   pc_keep,
  output logic                   ifid_keep,
  output logic                   ifid_flush,
  output logic                   idex_keep,
  output logic                   idex_flush,
  output logic                   exmem_keep,
  output logic                   memwb_flush,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef enum logic {StRun, StWait} state_e;

  localparam logic [3:0] WaitInit = (MEM_WAIT > 0) ? 4'(MEM_WAIT - 1) : 4'd0;

  state_e            state_q, state_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_q;

  logic [REG_AW-1:0] rk;
  logic              lu_hit, fwd_hit, lu, raw;
  logic              hold_all, fin, br_flush, bubble;

  // Operand match against EX/MEM writers; WB writers never conflict.
  always_comb begin
    rk      = '0;
    lu_hit  = 1'b0;
    fwd_hit = 1'b0;
    for (int k = 0; k < int'(N_RD); k++) begin
      rk = id_rreg[k*REG_AW +: REG_AW];
      if (id_use[k]) begin
        if (rk == ex_wreg) lu_hit = 1'b1;
        if ((ex_wen && rk == ex_wreg) || (mem_wen && rk == mem_wreg)) fwd_hit = 1'b1;
      end
    end
    lu  = ex_memread & ex_wen & lu_hit;
    raw = lu | ((FWD_EN == 0) ? fwd_hit : 1'b0);
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    hold_all = 1'b0;
    fin      = 1'b0;
    br_flush = 1'b0;
    bubble   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (mem_conflict) begin
          if (MEM_WAIT > 0) begin
            hold_all = 1'b1;
            wcnt_d   = WaitInit;
            state_d  = StWait;
          end else begin
            fin = 1'b1;
          end
        end else if (ex_branch_taken) begin
          br_flush = 1'b1;
        end else if (raw) begin
          bubble = 1'b1;
        end
      end
      StWait: begin
        if (wcnt_q != 4'd0) begin
          hold_all = 1'b1;
          wcnt_d   = wcnt_q - 4'd1;
        end else begin
          fin     = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
  end

  // Final wait cycle refetches; a taken branch there redirects the PC instead.
  always_comb begin
    pc_keep     = ~rst & (hold_all | bubble | (fin & ~ex_branch_taken));
    ifid_keep   = ~rst & (hold_all | bubble);
    ifid_flush  = ~rst & (fin | br_flush);
    idex_keep   = ~rst & hold_all;
    idex_flush  = ~rst & (bubble | br_flush | (fin & ex_branch_taken));
    exmem_keep  = ~rst & hold_all;
    memwb_flush = ~rst & hold_all;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      wcnt_q  <= 4'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      if (pc_keep && stall_q != '1) stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; three instances with different
// FWD_EN / MEM_WAIT / CNT_W share one stimulus bus.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] id_rreg;
  logic [1:0] id_use;
  logic [3:0] ex_wreg, mem_wreg;
  logic       ex_wen, ex_memread, ex_branch_taken, mem_wen, mem_conflict;

  // {pc_keep, ifid_keep, ifid_flush, idex_keep, idex_flush, exmem_keep, memwb_flush}
  logic [6:0]  ctl_a, ctl_b, ctl_c;
  logic [15:0] cnt_a, cnt_c;
  logic [1:0]  cnt_b;

  localparam logic [6:0] Idle   = 7'b0000000;
  localparam logic [6:0] Hold   = 7'b1101011;
  localparam logic [6:0] Fin    = 7'b1010000;
  localparam logic [6:0] Flush  = 7'b0010100;
  localparam logic [6:0] Bubble = 7'b1100100;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(4), .N_RD(2), .MEM_WAIT(1), .FWD_EN(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_rreg(id_rreg), .id_use(id_use), .ex_wreg(ex_wreg),
    .ex_wen(ex_wen), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_wreg(mem_wreg), .mem_wen(mem_wen), .mem_conflict(mem_conflict),
    .pc_keep(ctl_a[6]), .ifid_keep(ctl_a[5]), .ifid_flush(ctl_a[4]), .idex_keep(ctl_a[3]),
    .idex_flush(ctl_a[2]), .exmem_keep(ctl_a[1]), .memwb_flush(ctl_a[0]), .stall_cnt(cnt_a)
  );

  pipe_hazard_ctrl #(.REG_AW(4), .N_RD(2), .MEM_WAIT(2), .FWD_EN(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .id_rreg(id_rreg), .id_use(id_use), .ex_wreg(ex_wreg),
    .ex_wen(ex_wen), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_wreg(mem_wreg), .mem_wen(mem_wen), .mem_conflict(mem_conflict),
    .pc_keep(ctl_b[6]), .ifid_keep(ctl_b[5]), .ifid_flush(ctl_b[4]), .idex_keep(ctl_b[3]),
    .idex_flush(ctl_b[2]), .exmem_keep(ctl_b[1]), .memwb_flush(ctl_b[0]), .stall_cnt(cnt_b)
  );

  pipe_hazard_ctrl #(.REG_AW(4), .N_RD(2), .MEM_WAIT(0), .FWD_EN(1), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .id_rreg(id_rreg), .id_use(id_use), .ex_wreg(ex_wreg),
    .ex_wen(ex_wen), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken),
    .mem_wreg(mem_wreg), .mem_wen(mem_wen), .mem_conflict(mem_conflict),
    .pc_keep(ctl_c[6]), .ifid_keep(ctl_c[5]), .ifid_flush(ctl_c[4]), .idex_keep(ctl_c[3]),
    .idex_flush(ctl_c[2]), .exmem_keep(ctl_c[1]), .memwb_flush(ctl_c[0]), .stall_cnt(cnt_c)
  );

  task automatic clear_inputs();
    id_rreg = '0; id_use = '0; ex_wreg = '0; mem_wreg = '0;
    ex_wen = 0; ex_memread = 0; ex_branch_taken = 0; mem_wen = 0; mem_conflict = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_conflict = 1; ex_branch_taken = 1; ex_memread = 1; ex_wen = 1; id_use = 2'b11;
    #1;
    n_cmp++; if (ctl_a !== Idle) begin n_bad++; $display("FAIL reset_ctl_a got %b want %b", ctl_a, Idle); end
    n_cmp++; if (ctl_b !== Idle) begin n_bad++; $display("FAIL reset_ctl_b got %b want %b", ctl_b, Idle); end
    n_cmp++; if (ctl_c !== Idle) begin n_bad++; $display("FAIL reset_ctl_c got %b want %b", ctl_c, Idle); end
    n_cmp++; if (cnt_a !== 16'd0) begin n_bad++; $display("FAIL reset_cnt_a got %0d want 0", cnt_a); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_load_use();
    do_reset();
    @(negedge clk);
    ex_memread = 1; ex_wen = 1; ex_wreg = 4'd3; id_rreg = {4'd0, 4'd3}; id_use = 2'b00;
    #1;
    n_cmp++; if (ctl_a !== Idle) begin n_bad++; $display("FAIL lu_unused got %b want %b", ctl_a, Idle); end
    @(negedge clk);
    id_use = 2'b01;
    #1;
    n_cmp++; if (ctl_a !== Bubble) begin n_bad++; $display("FAIL lu_bubble got %b want %b", ctl_a, Bubble); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (ctl_a !== Idle) begin n_bad++; $display("FAIL lu_release got %b want %b", ctl_a, Idle); end
    n_cmp++; if (cnt_a !== 16'd1) begin n_bad++; $display("FAIL lu_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_raw_nofwd();
    do_reset();
    @(negedge clk);
    mem_wen = 1; mem_wreg = 4'd5; id_rreg = {4'd5, 4'd0}; id_use = 2'b10;
    #1;
    n_cmp++; if (ctl_b !== Bubble) begin n_bad++; $display("FAIL raw_mem_nofwd got %b want %b", ctl_b, Bubble); end
    n_cmp++; if (ctl_a !== Idle) begin n_bad++; $display("FAIL raw_mem_fwd got %b want %b", ctl_a, Idle); end
    @(negedge clk);
    clear_inputs();
    ex_wen = 1; ex_wreg = 4'd7; id_rreg = {4'd0, 4'd7}; id_use = 2'b01;
    #1;
    n_cmp++; if (ctl_b !== Bubble) begin n_bad++; $display("FAIL raw_ex_nofwd got %b want %b", ctl_b, Bubble); end
    n_cmp++; if (ctl_a !== Idle) begin n_bad++; $display("FAIL raw_ex_fwd got %b want %b", ctl_a, Idle); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_structural();
    do_reset();
    @(negedge clk);
    mem_conflict = 1;
    #1;
    n_cmp++; if (ctl_b !== Hold) begin n_bad++; $display("FAIL st_b_c0 got %b want %b", ctl_b, Hold); end
    n_cmp++; if (ctl_a !== Hold) begin n_bad++; $display("FAIL st_a_c0 got %b want %b", ctl_a, Hold); end
    n_cmp++; if (ctl_c !== Fin) begin n_bad++; $display("FAIL st_c_c0 got %b want %b", ctl_c, Fin); end
    @(negedge clk);
    #1;
    n_cmp++; if (ctl_b !== Hold) begin n_bad++; $display("FAIL st_b_c1 got %b want %b", ctl_b, Hold); end
    n_cmp++; if (ctl_a !== Fin) begin n_bad++; $display("FAIL st_a_c1 got %b want %b", ctl_a, Fin); end
    @(negedge clk);
    #1;
    n_cmp++; if (ctl_b !== Fin) begin n_bad++; $display("FAIL st_b_c2 got %b want %b", ctl_b, Fin); end
    @(negedge clk);
    mem_conflict = 0;
    #1;
    n_cmp++; if (ctl_b !== Idle) begin n_bad++; $display("FAIL st_b_c3 got %b want %b", ctl_b, Idle); end
    n_cmp++; if (cnt_b !== 2'd3) begin n_bad++; $display("FAIL st_b_cnt got %0d want 3", cnt_b); end
  endtask

  task automatic test_branch_final();
    do_reset();
    @(negedge clk);
    mem_conflict = 1; ex_branch_taken = 1;
    #1;
    n_cmp++; if (ctl_a !== Hold) begin n_bad++; $display("FAIL brw_a_c0 got %b want %b", ctl_a, Hold); end
    n_cmp++; if (ctl_c !== Flush) begin n_bad++; $display("FAIL brw_c_mw0 got %b want %b", ctl_c, Flush); end
    @(negedge clk);
    mem_conflict = 0;
    #1;
    n_cmp++; if (ctl_a !== Flush) begin n_bad++; $display("FAIL brw_a_c1 got %b want %b", ctl_a, Flush); end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (cnt_a !== 16'd1) begin n_bad++; $display("FAIL brw_a_cnt got %0d want 1", cnt_a); end
  endtask

  task automatic test_priority();
    do_reset();
    @(negedge clk);
    ex_branch_taken = 1; ex_memread = 1; ex_wen = 1; ex_wreg = 4'd2;
    id_rreg = {4'd2, 4'd2}; id_use = 2'b11;
    #1;
    n_cmp++; if (ctl_a !== Flush) begin n_bad++; $display("FAIL prio_br_lu got %b want %b", ctl_a, Flush); end
    n_cmp++; if (ctl_b !== Flush) begin n_bad++; $display("FAIL prio_br_raw got %b want %b", ctl_b, Flush); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    @(negedge clk);
    ex_memread = 1; ex_wen = 1; ex_wreg = 4'd9; id_rreg = {4'd9, 4'd1}; id_use = 2'b10;
    repeat (5) @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++; if (cnt_b !== 2'd3) begin n_bad++; $display("FAIL sat_b got %0d want 3", cnt_b); end
    n_cmp++; if (cnt_a !== 16'd5) begin n_bad++; $display("FAIL sat_a got %0d want 5", cnt_a); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    @(negedge clk);
    mem_conflict = 1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++; if (ctl_b !== Idle) begin n_bad++; $display("FAIL rstw_b got %b want %b", ctl_b, Idle); end
    n_cmp++; if (ctl_a !== Idle) begin n_bad++; $display("FAIL rstw_a got %b want %b", ctl_a, Idle); end
    n_cmp++; if (cnt_b !== 2'd0) begin n_bad++; $display("FAIL rstw_cnt got %0d want 0", cnt_b); end
    @(negedge clk);
    rst = 1'b0;
    mem_conflict = 0; ex_branch_taken = 1;
    #1;
    n_cmp++; if (ctl_b !== Flush) begin n_bad++; $display("FAIL rstw_run got %b want %b", ctl_b, Flush); end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_load_use();
    test_raw_nofwd();
    test_structural();
    test_branch_final();
    test_priority();
    test_saturation();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
